gen_named_src: RTL and testbench
================================

Name: gen_named_src

Overview:
- Stream source that produces the words consumed by the interface-attached consumer stage in the generate-named test hierarchy.
- Generates COUNT words from a pattern generator selected by generate-if on MODE.
- Words pass through a 2-entry output buffer and leave on a valid/ready handshake.
- Reports completion and the number of words sent, so the bench can finish once traffic is drained.

Parameters:
- WIDTH, 8, data word width in bits.
- COUNT, 16, words generated per run; must be 1 or more.
- MODE, 0, pattern select: 0 = incrementing, 1 = Galois LFSR. MODE 1 requires WIDTH == 8; any other width is an elaboration error, raised from a generate branch.
- SEED, 1, first word of each run.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin a run.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts a word.
- out_data  output  WIDTH  buffer head word.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- sent_count  output  $clog2(COUNT+1)  words transferred this run.
- checksum  output  WIDTH  XOR of words transferred (see Optional Feature).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset values: all outputs 0, state IDLE, buffer empty, generator register = SEED. SEED 0 in MODE 1 is replaced by 1.
- A transfer occurs on any clk edge where out_valid && out_ready.
- States:
  - IDLE: start -> RUN. Generator loads SEED; gen_index and sent_count clear.
  - RUN: each cycle the buffer is not full, or the buffer is full and a transfer occurs that cycle, push the current generator word, advance the generator and increment gen_index. When gen_index reaches COUNT -> DRAIN.
  - DRAIN: no pushes. When the buffer becomes empty -> DONE.
  - DONE: done = 1, held. start -> RUN with the same reload as from IDLE. done drops the cycle RUN is entered.
- start is ignored in RUN and DRAIN.
- Latency: start sampled at edge N -> out_valid = 1 after edge N+1, with out_data = SEED.
- Buffer:
  - 2-entry FIFO; out_data is driven from a register, never combinationally from the generator.
  - Push and pop in the same cycle are allowed when full or when holding one entry; occupancy is unchanged.
  - No push while full without a pop; no word is ever dropped or duplicated.
  - out_valid and out_data are held stable while out_ready is low.
- Patterns:
  - MODE 0: word_i = (SEED + i) mod 2^WIDTH, wrapping silently.
  - MODE 1: next = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00).
- sent_count increments on each transfer and saturates at COUNT.
- Back-to-back: with out_ready held high, one transfer per cycle. A run takes COUNT+1 cycles from start to the last transfer, and DONE is entered one cycle later.
- Reset mid-run: immediate return to reset values; in-flight words are discarded.

Optional Feature:
- Macro: GEN_NAMED_SRC_CHECKSUM_EN.
- Defined: checksum is an XOR accumulator updated with out_data on every transfer. It is cleared on reset and on run start, and holds its value in DONE.
- Undefined: no accumulator logic; checksum is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Incrementing run, continuous ready: MODE 0, SEED 8'hFE, COUNT 4, out_ready = 1, start pulse -> words FE, FF, 00, 01 on consecutive cycles; sent_count = 4; done = 1 one cycle after the last transfer.
- LFSR run: MODE 1, SEED 8'h01, COUNT 4 -> words 01, B8, 5C, 2E. With the macro defined, checksum = 8'hCB.
- Backpressure: COUNT 16, out_ready low for 5 cycles after start -> out_valid = 1 and out_data = SEED held for all 5 cycles. When ready rises, all 16 words arrive in order with no gaps, no drops and no duplicates.
- Alternating ready (1010...): COUNT 8 -> exactly 8 transfers in order; busy stays high until the last transfer; done follows it.
- Ignored start: pulse start during RUN and again during DRAIN -> the sequence is unaffected; sent_count ends at COUNT.
- Reset mid-run: assert rst after 3 transfers of COUNT 16 -> all outputs 0 immediately. A new start then replays the sequence from SEED.

Source files
------------

// File: rtl/gen_named_src.sv
// Counted word source (incrementing or LFSR) behind a 2-entry output buffer; optional GEN_NAMED_SRC_CHECKSUM_EN XOR accumulator.
// First word valid one cycle after the start edge; out_ready low holds out_data stable and stalls the generator when the buffer is full.
module gen_named_src #(
  parameter int WIDTH = 8,
  parameter int COUNT = 16,
  parameter int MODE  = 0,
  parameter int SEED  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(COUNT+1)-1:0]   sent_count,
  output logic [WIDTH-1:0]             checksum
);

  localparam int CW = $clog2(COUNT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1 in that mode.
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_EFF = (MODE == 1 && SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [CW-1:0]    LAST_IDX = CW'(COUNT - 1);
  localparam logic [CW-1:0]    COUNT_W  = CW'(COUNT);

  logic [1:0]       state;
  logic [WIDTH-1:0] gen_q;
  logic [WIDTH-1:0] gen_next;
  logic [CW-1:0]    gen_index;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       occ;
  logic             xfer;
  logic             push;
  logic             load;

  generate
    if (MODE == 0) begin : g_inc
      assign gen_next = gen_q + WIDTH'(1);
    end else if (MODE == 1 && WIDTH == 8) begin : g_lfsr
      assign gen_next = (gen_q >> 1) ^ (gen_q[0] ? WIDTH'(8'hB8) : '0);
    end else begin : g_bad
      $error("gen_named_src: MODE must be 0, or 1 with WIDTH == 8");
      assign gen_next = gen_q;
    end
  endgenerate

  assign out_valid = (occ != 2'd0);
  assign out_data  = head_q;
  assign xfer      = out_valid && out_ready;
  assign load      = start && (state == ST_IDLE || state == ST_DONE);
  assign push      = (state == ST_RUN) && (occ != 2'd2 || xfer);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start) state <= ST_RUN;
        ST_RUN:           if (push && gen_index == LAST_IDX) state <= ST_DRAIN;
        // Registered emptiness check puts DONE one cycle after the final transfer.
        ST_DRAIN:         if (occ == 2'd0) state <= ST_DONE;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q     <= SEED_EFF;
      gen_index <= '0;
    end else if (load) begin
      gen_q     <= SEED_EFF;
      gen_index <= '0;
    end else if (push) begin
      gen_q     <= gen_next;
      gen_index <= gen_index + CW'(1);
    end
  end

  // Head register feeds out_data directly; tail only holds the second entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, xfer})
        2'b10: begin
          if (occ == 2'd0) head_q <= gen_q;
          else             tail_q <= gen_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          if (occ == 2'd2) head_q <= tail_q;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= gen_q;
          end else begin
            head_q <= tail_q;
            tail_q <= gen_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_count <= '0;
    end else if (load) begin
      sent_count <= '0;
    end else if (xfer && sent_count != COUNT_W) begin
      sent_count <= sent_count + CW'(1);
    end
  end

`ifdef GEN_NAMED_SRC_CHECKSUM_EN
  logic [WIDTH-1:0] cks_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cks_q <= '0;
    end else if (load) begin
      cks_q <= '0;
    end else if (xfer) begin
      cks_q <= cks_q ^ out_data;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_gen_named_src.sv
// Directed bench for gen_named_src: four instances covering incrementing wrap, LFSR, backpressure, alternating ready, ignored start and mid-run reset.
module tb_gen_named_src;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // a: incrementing, SEED FE, COUNT 4
  logic a_start, a_rdy, a_vld, a_busy, a_done;
  logic [7:0] a_dat, a_cks;
  logic [2:0] a_sent;
  // b: LFSR, SEED 01, COUNT 4
  logic b_start, b_rdy, b_vld, b_busy, b_done;
  logic [7:0] b_dat, b_cks;
  logic [2:0] b_sent;
  // c: incrementing, SEED F8, COUNT 16
  logic c_start, c_rdy, c_vld, c_busy, c_done;
  logic [7:0] c_dat, c_cks;
  logic [4:0] c_sent;
  // d: LFSR, SEED 0 (promoted to 1), COUNT 8
  logic d_start, d_rdy, d_vld, d_busy, d_done;
  logic [7:0] d_dat, d_cks;
  logic [3:0] d_sent;

  gen_named_src #(.WIDTH(8), .COUNT(4), .MODE(0), .SEED(8'hFE)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .out_valid(a_vld), .out_ready(a_rdy),
    .out_data(a_dat), .busy(a_busy), .done(a_done), .sent_count(a_sent), .checksum(a_cks));

  gen_named_src #(.WIDTH(8), .COUNT(4), .MODE(1), .SEED(8'h01)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .out_valid(b_vld), .out_ready(b_rdy),
    .out_data(b_dat), .busy(b_busy), .done(b_done), .sent_count(b_sent), .checksum(b_cks));

  gen_named_src #(.WIDTH(8), .COUNT(16), .MODE(0), .SEED(8'hF8)) u_c (
    .clk(clk), .rst(rst), .start(c_start), .out_valid(c_vld), .out_ready(c_rdy),
    .out_data(c_dat), .busy(c_busy), .done(c_done), .sent_count(c_sent), .checksum(c_cks));

  gen_named_src #(.WIDTH(8), .COUNT(8), .MODE(1), .SEED(0)) u_d (
    .clk(clk), .rst(rst), .start(d_start), .out_valid(d_vld), .out_ready(d_rdy),
    .out_data(d_dat), .busy(d_busy), .done(d_done), .sent_count(d_sent), .checksum(d_cks));

  logic [7:0] exp_lf [8] = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8};

`ifdef GEN_NAMED_SRC_CHECKSUM_EN
  localparam logic [31:0] EXP_CKS_B = 32'hCB;
`else
  localparam logic [31:0] EXP_CKS_B = 32'h0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] w;
    int k, last, done_at;

    rst = 1'b1;
    a_start = 0; b_start = 0; c_start = 0; d_start = 0;
    a_rdy = 1; b_rdy = 1; c_rdy = 0; d_rdy = 0;
    repeat (2) tick;
    rst = 1'b0;
    tick;

    chk("rst_valid", 32'(a_vld), 0);
    chk("rst_data",  32'(a_dat), 0);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_done",  32'(a_done), 0);
    chk("rst_sent",  32'(c_sent), 0);
    chk("rst_cks",   32'(b_cks), 0);
    chk("rst_data_d", 32'(d_dat), 0);

    // Incrementing with wrap and LFSR, continuous ready
    a_start = 1; b_start = 1;
    tick;
    a_start = 0; b_start = 0;
    chk("start_busy", 32'(a_busy), 1);
    chk("start_valid_lat", 32'(a_vld), 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      w = 8'hFE + 8'(i);
      chk("inc_valid", 32'(a_vld), 1);
      chk("inc_data",  32'(a_dat), 32'(w));
      chk("inc_sent",  32'(a_sent), 32'(i));
      chk("lfsr_data", 32'(b_dat), 32'(exp_lf[i]));
      tick;
    end
    chk("inc_drained_valid", 32'(a_vld), 0);
    chk("inc_sent_final", 32'(a_sent), 4);
    chk("inc_drain_busy", 32'(a_busy), 1);
    chk("inc_drain_done", 32'(a_done), 0);
    tick;
    chk("inc_done", 32'(a_done), 1);
    chk("inc_done_busy", 32'(a_busy), 0);
    chk("lfsr_done", 32'(b_done), 1);
    chk("lfsr_sent", 32'(b_sent), 4);
    chk("lfsr_cks", 32'(b_cks), EXP_CKS_B);
    tick;
    chk("inc_done_held", 32'(a_done), 1);
    chk("lfsr_cks_held", 32'(b_cks), EXP_CKS_B);

    // Backpressure for 5 cycles, then drain; start pulses in RUN and DRAIN
    c_start = 1;
    tick;
    c_start = 0;
    for (int i = 0; i < 5; i++) begin
      c_start = (i == 1);
      tick;
      c_start = 0;
      chk("bp_hold_valid", 32'(c_vld), 1);
      chk("bp_hold_data",  32'(c_dat), 32'h00F8);
    end
    c_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      w = 8'hF8 + 8'(i);
      c_start = (i == 14);
      if (i == 14) chk("bp_drain_busy", 32'(c_busy), 1);
      chk("bp_valid", 32'(c_vld), 1);
      chk("bp_data",  32'(c_dat), 32'(w));
      tick;
      c_start = 0;
    end
    chk("bp_empty", 32'(c_vld), 0);
    chk("bp_sent", 32'(c_sent), 16);
    tick;
    chk("bp_done", 32'(c_done), 1);
    chk("bp_sent_hold", 32'(c_sent), 16);

    // Alternating ready, LFSR with zero seed
    d_start = 1;
    tick;
    d_start = 0;
    k = 0; last = -1; done_at = -1;
    for (int t = 0; t < 80 && done_at < 0; t++) begin
      d_rdy = (t % 2 == 0);
      if (k < 8) chk("alt_busy", 32'(d_busy), 1);
      if (d_done) done_at = t;
      else if (d_vld && d_rdy) begin
        chk("alt_data", 32'(d_dat), 32'(exp_lf[k & 7]));
        k++;
        last = t;
      end
      tick;
    end
    d_rdy = 0;
    chk("alt_count", 32'(k), 8);
    chk("alt_done_delay", 32'(done_at - last), 2);
    chk("alt_sent", 32'(d_sent), 8);

    // Reset mid-run, then replay from SEED (start from DONE)
    c_start = 1;
    tick;
    c_start = 0;
    chk("restart_done_drop", 32'(c_done), 0);
    chk("restart_busy", 32'(c_busy), 1);
    repeat (4) tick;
    chk("mid_sent", 32'(c_sent), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(c_vld), 0);
    chk("mr_data",  32'(c_dat), 0);
    chk("mr_busy",  32'(c_busy), 0);
    chk("mr_sent",  32'(c_sent), 0);
    chk("mr_done_a", 32'(a_done), 0);
    tick;
    rst = 1'b0;
    c_start = 1;
    tick;
    c_start = 0;
    tick;
    for (int i = 0; i < 3; i++) begin
      w = 8'hF8 + 8'(i);
      chk("replay_data", 32'(c_dat), 32'(w));
      tick;
    end
    chk("replay_sent", 32'(c_sent), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
